mccu_xh: RTL
============

// Module: mccu_xh
// PURPOSE
//  Multicycle MIPS control unit with memory ready handshake, bus timeout, interrupt and illegal-op traps.
//  Decodes op/func, sequences IF/ID/EXE/MEM/WB plus trap-entry state, drives datapath enables/selects.
//  Sits between instruction register decode fields and the multicycle datapath (PC, IR, regfile, ALU, EPC).
// PARAMETERS
//  MEM_TIMEOUT  15  wait cycles before bus-error trap; 0 disables timeout
//  TO_W         4   timeout counter width, >= clog2(MEM_TIMEOUT+1)
//  ENABLE_IRQ   1   0: irq ignored, ie tied 0
// PORTS
//  clock      in   1  clock, rising edge
//  resetn     in   1  asynchronous reset, active-high
//  op         in   6  IR[31:26]
//  func       in   6  IR[5:0]
//  z          in   1  ALU zero flag
//  mem_ready  in   1  memory completes current access this cycle
//  irq        in   1  level interrupt request
//  mem_req    out  1  memory access active (sif, smem)
//  wpc,wir,wmem,wreg,iord,regrt,m2reg,shift,alusrca,jal,sext  out 1 each, as in mccu
//  aluc out 4; alusrcb out 2; pcsource out 3 (0 pc+4,1 branch,2 rs,3 jump,4 vector,5 EPC)
//  wepc       out  1  EPC <= PC
//  cause      out  2  trap cause, valid with wepc: 0 irq,1 illegal op,2 bus timeout
//  ie         out  1  interrupt-enable flag
//  state      out  3  current state
// BEHAVIOUR
//  States: sif=0 sid=1 sexe=2 smem=3 swb=4 sexc=5; 6,7 -> sif. Outputs combinational from state/inputs.
//  Defaults every state: all enables 0, aluc 0, alusrcb 0, pcsource 0, sext 1, cause 0.
//  Reset: state sif, tocnt 0, ie=ENABLE_IRQ, pending cause 0; mid-operation reset aborts access, no write.
//  sif: if irq&ie at entry cycle (tocnt==0) -> sexc cause 0, no fetch. Else mem_req=1, alusrca=1,
//   alusrcb=1; wpc=wir=mem_ready; mem_ready -> sid; else tocnt++, stay; tocnt==MEM_TIMEOUT -> sexc cause 2.
//  sid: j: pcsrc3 wpc; jal: pcsrc3 wpc jal wreg; jr: pcsrc2 wpc; jalr: pcsrc2 wpc jal wreg; all -> sif.
//   eret (op 010000,func 011000): pcsrc5 wpc, ie<=1 -> sif. Unknown op/func -> sexc cause 1.
//   Else alusrca=1 alusrcb=3 aluc=0 -> sexe.
//  Supported: add sub and or xor nor slt sll srl sra jr jalr addi andi ori xori slti lui lw sw beq bne j jal eret.
//  sexe: aluc[3]=sra|slt|nor|slti; [2]=sub|or|srl|sra|ori|lui|nor; [1]=xor|sll|srl|sra|xori|beq|bne|lui;
//   [0]=and|or|sll|srl|sra|andi|ori|nor. beq/bne: pcsrc1, wpc=beq&z|bne&~z -> sif.
//   lw/sw: alusrcb2 -> smem. Else shift for sll/srl/sra; alusrcb2 for imm ops; sext 0 andi/ori/xori -> swb.
//  smem: mem_req=1 iord=1; sw: wmem=mem_ready. Wait/timeout as sif. Ready: lw -> swb, sw -> sif.
//   Timeout: no wmem/wreg; -> sexc cause 2.
//  swb: wreg=1; m2reg lw; regrt for lw and imm ops -> sif.
//  sexc: wepc=1, cause=latched, pcsource=4, wpc=1, ie<=0 -> sif. One cycle.
//  tocnt: cleared on each state change; saturates; ready wins over simultaneous timeout.
//  irq sampled only at sif entry; irq during wait not taken until next fetch boundary.
//  EPC semantics: irq -> address of unfetched instr; illegal/sw/lw trap -> PC already +4.
// STRUCTURE
//  Package mccu_pkg: state encodings, ALUC_* codes, PCSRC_* codes, CAUSE_* codes, opcode/func constants.
//  Sub-module mccu_decode: combinational op/func -> one-hot instruction flags + illegal flag.
//  Top holds state register, tocnt, ie, cause latch and output case block.
// TESTING
//  add, mem_ready=1 always -> states 0,1,2,4,0; swb wreg=1 regrt=0; sexe aluc=0000.
//  lw, mem_ready low 3 cycles in smem -> 3 stall cycles, iord=1, no wreg until swb, m2reg=1.
//  sw, mem_ready never high, MEM_TIMEOUT=15 -> 15 wait cycles in smem, wmem=0, sexc cause=2, pcsource=4.
//  irq=1, ie=1 at sif -> sexc cause=0 wepc=1 wpc=1; ie=0 after; eret -> pcsource=5, ie=1.
//  op=111111 -> sid -> sexc cause=1; bne z=0 -> wpc=1 pcsource=1; beq z=0 -> wpc=0.
//  resetn pulse mid smem of sw -> state=0, wmem=0, tocnt=0, ie=1 next cycle.

Source files
------------

// File: rtl/mccu_pkg.sv
// mccu_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_t    : FSM state encodings (visible on the 'state' port)
//   - ALUC_*     : ALU operation codes
//   - PCSRC_*    : next-PC mux selects
//   - ALUSRCB_*  : ALU B-operand mux selects
//   - CAUSE_*    : trap cause codes presented with wepc
//   - OP_*/F_*   : opcode and function-field constants
//   - insn_t     : one-hot decoded instruction flags from mccu_decode
package mccu_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_EXC = 3'd5
   } state_t;

   localparam logic [3:0] ALUC_ADD = 4'b0000;

   localparam logic [2:0] PCSRC_PC4    = 3'd0;
   localparam logic [2:0] PCSRC_BRANCH = 3'd1;
   localparam logic [2:0] PCSRC_RS     = 3'd2;
   localparam logic [2:0] PCSRC_JUMP   = 3'd3;
   localparam logic [2:0] PCSRC_VECTOR = 3'd4;
   localparam logic [2:0] PCSRC_EPC    = 3'd5;

   localparam logic [1:0] ALUSRCB_REG  = 2'd0;
   localparam logic [1:0] ALUSRCB_FOUR = 2'd1;
   localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
   localparam logic [1:0] ALUSRCB_BOFF = 2'd3;

   localparam logic [1:0] CAUSE_IRQ = 2'd0;
   localparam logic [1:0] CAUSE_ILL = 2'd1;
   localparam logic [1:0] CAUSE_BUS = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;
   localparam logic [5:0] F_ERET = 6'b011000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   // 'add' has no flag: its ALU code and datapath selects are all defaults,
   // so it only has to be recognised as legal.
   typedef struct packed {
      logic sub, and_, or_, xor_, nor_, slt, sll, srl, sra, jr, jalr;
      logic addi, andi, ori, xori, slti, lui;
      logic lw, sw, beq, bne, j, jal, eret;
      logic illegal;
   } insn_t;

endpackage

// File: rtl/mccu_decode.sv
// mccu_decode: combinational instruction decoder.
//   op   in  6  IR[31:26]
//   func in  6  IR[5:0]
//   ins  out    one-hot instruction flags; ins.illegal set for any
//               op/func pair outside the supported set
module mccu_decode
   import mccu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output insn_t      ins
);

   always_comb begin
      ins = '0;
      case (op)
         OP_RTYPE: begin
            case (func)
               F_ADD:   ;
               F_SUB:   ins.sub  = 1'b1;
               F_AND:   ins.and_ = 1'b1;
               F_OR:    ins.or_  = 1'b1;
               F_XOR:   ins.xor_ = 1'b1;
               F_NOR:   ins.nor_ = 1'b1;
               F_SLT:   ins.slt  = 1'b1;
               F_SLL:   ins.sll  = 1'b1;
               F_SRL:   ins.srl  = 1'b1;
               F_SRA:   ins.sra  = 1'b1;
               F_JR:    ins.jr   = 1'b1;
               F_JALR:  ins.jalr = 1'b1;
               default: ins.illegal = 1'b1;
            endcase
         end
         OP_COP0: begin
            if (func == F_ERET) ins.eret = 1'b1;
            else                ins.illegal = 1'b1;
         end
         OP_ADDI: ins.addi = 1'b1;
         OP_ANDI: ins.andi = 1'b1;
         OP_ORI:  ins.ori  = 1'b1;
         OP_XORI: ins.xori = 1'b1;
         OP_SLTI: ins.slti = 1'b1;
         OP_LUI:  ins.lui  = 1'b1;
         OP_LW:   ins.lw   = 1'b1;
         OP_SW:   ins.sw   = 1'b1;
         OP_BEQ:  ins.beq  = 1'b1;
         OP_BNE:  ins.bne  = 1'b1;
         OP_J:    ins.j    = 1'b1;
         OP_JAL:  ins.jal  = 1'b1;
         default: ins.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mccu_xh.sv
// mccu_xh: multicycle MIPS control unit with memory-ready handshake,
// bus timeout, interrupt and illegal-instruction traps.
//   clock, resetn          rising-edge clock; async active-high reset
//   op, func               IR decode fields
//   z                      ALU zero flag
//   mem_ready, irq         memory completion, level interrupt request
//   mem_req                memory access in progress (fetch or data)
//   wpc wir wmem wreg iord regrt m2reg shift alusrca jal sext
//                          datapath enables / selects
//   aluc[3:0] alusrcb[1:0] pcsource[2:0]
//   wepc, cause[1:0]       EPC write and trap cause (cause valid with wepc)
//   ie                     interrupt-enable flag
//   state[2:0]             current FSM state
//
// Memory handshake: mem_req is high for every cycle of a fetch (S_IF) or data
// access (S_MEM); the access completes in the cycle mem_ready is high, and
// the write strobes (wir/wpc on fetch, wmem on store) are qualified by that
// same mem_ready. If MEM_TIMEOUT != 0 and the access has waited MEM_TIMEOUT
// cycles without mem_ready, the access is abandoned into a bus-error trap.
module mccu_xh
   import mccu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4,
   parameter bit ENABLE_IRQ  = 1'b1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   input  logic       irq,
   output logic       mem_req,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic       regrt,
   output logic       m2reg,
   output logic       shift,
   output logic       alusrca,
   output logic       jal,
   output logic       sext,
   output logic [3:0] aluc,
   output logic [1:0] alusrcb,
   output logic [2:0] pcsource,
   output logic       wepc,
   output logic [1:0] cause,
   output logic       ie,
   output logic [2:0] state
);

   insn_t            ins;
   state_t           state_q, state_d;
   logic [TO_W-1:0]  tocnt_q, tocnt_d, tocnt_inc;
   logic             ie_q, ie_d;
   logic [1:0]       cause_q, cause_d;
   logic             timed_out, irq_take, imm_op;

   mccu_decode u_decode (
      .op   (op),
      .func (func),
      .ins  (ins)
   );

   assign state    = state_q;
   assign ie       = ie_q;
   assign imm_op   = ins.addi | ins.andi | ins.ori | ins.xori | ins.slti | ins.lui;
   assign tocnt_inc = (&tocnt_q) ? tocnt_q : tocnt_q + TO_W'(1);
   assign timed_out = (MEM_TIMEOUT != 0) && (tocnt_q == TO_W'(MEM_TIMEOUT));
   // tocnt is zero only in the first cycle of S_IF, so an irq raised while a
   // fetch is stalled waits for the next instruction boundary.
   assign irq_take  = ie_q & irq & (tocnt_q == '0);

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_q <= S_IF;
         tocnt_q <= '0;
         ie_q    <= ENABLE_IRQ;
         cause_q <= CAUSE_IRQ;
      end else begin
         state_q <= state_d;
         tocnt_q <= tocnt_d;
         ie_q    <= ie_d & ENABLE_IRQ;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      mem_req  = 1'b0;
      wpc      = 1'b0;
      wir      = 1'b0;
      wmem     = 1'b0;
      wreg     = 1'b0;
      iord     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      shift    = 1'b0;
      alusrca  = 1'b0;
      jal      = 1'b0;
      sext     = 1'b1;
      aluc     = ALUC_ADD;
      alusrcb  = ALUSRCB_REG;
      pcsource = PCSRC_PC4;
      wepc     = 1'b0;
      cause    = CAUSE_IRQ;
      state_d  = state_q;
      tocnt_d  = '0;   // any state change clears the wait counter
      ie_d     = ie_q;
      cause_d  = cause_q;

      case (state_q)
         S_IF: begin
            if (irq_take) begin
               state_d = S_EXC;
               cause_d = CAUSE_IRQ;
            end else begin
               mem_req = 1'b1;
               alusrca = 1'b1;
               alusrcb = ALUSRCB_FOUR;
               wpc     = mem_ready;
               wir     = mem_ready;
               if (mem_ready) begin
                  state_d = S_ID;
               end else if (timed_out) begin
                  state_d = S_EXC;
                  cause_d = CAUSE_BUS;
               end else begin
                  tocnt_d = tocnt_inc;
               end
            end
         end

         S_ID: begin
            if (ins.j | ins.jal) begin
               pcsource = PCSRC_JUMP;
               wpc      = 1'b1;
               jal      = ins.jal;
               wreg     = ins.jal;
               state_d  = S_IF;
            end else if (ins.jr | ins.jalr) begin
               pcsource = PCSRC_RS;
               wpc      = 1'b1;
               jal      = ins.jalr;
               wreg     = ins.jalr;
               state_d  = S_IF;
            end else if (ins.eret) begin
               pcsource = PCSRC_EPC;
               wpc      = 1'b1;
               ie_d     = 1'b1;
               state_d  = S_IF;
            end else if (ins.illegal) begin
               state_d  = S_EXC;
               cause_d  = CAUSE_ILL;
            end else begin
               // Precompute the branch target while the register file is read.
               alusrca  = 1'b1;
               alusrcb  = ALUSRCB_BOFF;
               aluc     = ALUC_ADD;
               state_d  = S_EXE;
            end
         end

         S_EXE: begin
            aluc[3] = ins.sra | ins.slt | ins.nor_ | ins.slti;
            aluc[2] = ins.sub | ins.or_ | ins.srl | ins.sra | ins.ori | ins.lui | ins.nor_;
            aluc[1] = ins.xor_ | ins.sll | ins.srl | ins.sra | ins.xori | ins.beq | ins.bne
                      | ins.lui;
            aluc[0] = ins.and_ | ins.or_ | ins.sll | ins.srl | ins.sra | ins.andi | ins.ori
                      | ins.nor_;
            if (ins.beq | ins.bne) begin
               pcsource = PCSRC_BRANCH;
               wpc      = (ins.beq & z) | (ins.bne & ~z);
               state_d  = S_IF;
            end else if (ins.lw | ins.sw) begin
               alusrcb  = ALUSRCB_IMM;
               state_d  = S_MEM;
            end else begin
               shift    = ins.sll | ins.srl | ins.sra;
               if (imm_op) alusrcb = ALUSRCB_IMM;
               sext     = ~(ins.andi | ins.ori | ins.xori);
               state_d  = S_WB;
            end
         end

         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            wmem    = ins.sw & mem_ready;
            if (mem_ready) begin
               state_d = ins.lw ? S_WB : S_IF;
            end else if (timed_out) begin
               state_d = S_EXC;
               cause_d = CAUSE_BUS;
            end else begin
               tocnt_d = tocnt_inc;
            end
         end

         S_WB: begin
            wreg    = 1'b1;
            m2reg   = ins.lw;
            regrt   = ins.lw | imm_op;
            state_d = S_IF;
         end

         S_EXC: begin
            wepc     = 1'b1;
            cause    = cause_q;
            pcsource = PCSRC_VECTOR;
            wpc      = 1'b1;
            ie_d     = 1'b0;
            state_d  = S_IF;
         end

         default: state_d = S_IF;
      endcase
   end

endmodule
